axi_eth_tx_bridge: RTL

Parametrised successor of the TX side of the AXI Ethernet bridge. For every frame offered on the user data stream, it emits one AXI Ethernet TX control frame on `m_axis_txc`, then forwards the frame on `m_axis_txd`. Over the previous bridge it adds:
- configurable data width and control-frame length;
- per-frame checksum-offload fields, latched from config ports;
- a TX-status sink;
- frame and status counters.

It sits between the user DMA/packet source and the AXI Ethernet MAC TX interfaces.

---
 rtl/axi_eth_pkg.sv | 43 ++++
 rtl/axi_eth_txc_gen.sv | 89 ++++++++
 rtl/axi_eth_tx_bridge.sv | 129 ++++++++++++
 3 files changed

// File: rtl/axi_eth_pkg.sv
// Shared types and constants for the AXI Ethernet TX bridge: FSM states,
// control-frame flag, checksum modes and control-word layout.
package axi_eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TXC  = 2'd1,
        ST_TXD  = 2'd2
    } state_t;

    localparam logic [31:0] TXC_FLAG_NORMAL = 32'hA000_0000;

    localparam logic [1:0] CSUM_MODE_NONE    = 2'd0;
    localparam logic [1:0] CSUM_MODE_PARTIAL = 2'd1;
    localparam logic [1:0] CSUM_MODE_FULL    = 2'd2;

    localparam logic [15:0] TXC_IDX_FLAG   = 16'd0;
    localparam logic [15:0] TXC_IDX_MODE   = 16'd1;
    localparam logic [15:0] TXC_IDX_OFFSET = 16'd2;
    localparam logic [15:0] TXC_IDX_INIT   = 16'd3;

    // Words past the checksum fields are always zero padding.
    function automatic logic [31:0] txc_word(
        input logic [15:0] idx,
        input bit          csum_en,
        input logic [1:0]  mode,
        input logic [15:0] csum_beg,
        input logic [15:0] csum_ins,
        input logic [15:0] csum_init
    );
        logic [31:0] word;
        word = 32'h0;
        case (idx)
            TXC_IDX_FLAG:   word = TXC_FLAG_NORMAL;
            TXC_IDX_MODE:   word = csum_en ? {30'b0, mode} : 32'h0;
            TXC_IDX_OFFSET: word = csum_en ? {csum_beg, csum_ins} : 32'h0;
            TXC_IDX_INIT:   word = csum_en ? {16'b0, csum_init} : 32'h0;
            default:        word = 32'h0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/axi_eth_txc_gen.sv
// Control-frame generator: latches checksum config at frame start and emits
// TXC_WORDS registered words on the txc stream, pulsing txc_done on the last.
module axi_eth_txc_gen
    import axi_eth_pkg::*;
#(
    parameter int TXC_WORDS = 6,
    parameter bit CSUM_EN   = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        active,
    input  logic [1:0]  cfg_csum_mode,
    input  logic [15:0] cfg_csum_begin,
    input  logic [15:0] cfg_csum_insert,
    input  logic [15:0] cfg_csum_init,
    output logic [31:0] m_axis_txc_tdata,
    output logic [3:0]  m_axis_txc_tkeep,
    output logic        m_axis_txc_tlast,
    output logic        m_axis_txc_tvalid,
    input  logic        m_axis_txc_tready,
    output logic        txc_done
);

    localparam int IDX_W = $clog2(TXC_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TXC_WORDS - 1);

    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       mode_reg;
    logic [15:0]      beg_reg;
    logic [15:0]      ins_reg;
    logic [15:0]      init_reg;
    logic [31:0]      tdata_reg;
    logic             tvalid_reg;
    logic             tlast_reg;

    logic             handshake;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      load_word;

    assign handshake = tvalid_reg & m_axis_txc_tready;
    // First word loads from the cleared index; later words load the successor.
    assign load_idx  = tvalid_reg ? idx_reg + 1'b1 : idx_reg;
    assign load_word = txc_word(16'(load_idx), CSUM_EN, mode_reg, beg_reg, ins_reg, init_reg);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx_reg    <= '0;
            mode_reg   <= '0;
            beg_reg    <= '0;
            ins_reg    <= '0;
            init_reg   <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (start) begin
            idx_reg    <= '0;
            mode_reg   <= cfg_csum_mode;
            beg_reg    <= cfg_csum_begin;
            ins_reg    <= cfg_csum_insert;
            init_reg   <= cfg_csum_init;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (active) begin
            if (!tvalid_reg) begin
                tdata_reg  <= load_word;
                tvalid_reg <= 1'b1;
                tlast_reg  <= (load_idx == LAST_IDX);
            end else if (handshake) begin
                if (tlast_reg) begin
                    tdata_reg  <= '0;
                    tvalid_reg <= 1'b0;
                    tlast_reg  <= 1'b0;
                end else begin
                    idx_reg   <= load_idx;
                    tdata_reg <= load_word;
                    tlast_reg <= (load_idx == LAST_IDX);
                end
            end
        end
    end

    assign m_axis_txc_tdata  = tdata_reg;
    assign m_axis_txc_tkeep  = 4'hF;
    assign m_axis_txc_tlast  = tlast_reg;
    assign m_axis_txc_tvalid = tvalid_reg;
    assign txc_done          = handshake & tlast_reg;

endmodule

// File: rtl/axi_eth_tx_bridge.sv
// AXI Ethernet TX bridge: per user frame, one control frame on txc followed
// by a zero-latency passthrough of the frame on txd; sinks and counts TX status.
module axi_eth_tx_bridge
    import axi_eth_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TXC_WORDS  = 6,
    parameter bit CSUM_EN    = 1'b0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_txd_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_txd_tkeep,
    input  logic                    s_axis_txd_tlast,
    input  logic                    s_axis_txd_tvalid,
    output logic                    s_axis_txd_tready,
    input  logic [31:0]             s_axis_txs_tdata,
    input  logic [3:0]              s_axis_txs_tkeep,
    input  logic                    s_axis_txs_tlast,
    input  logic                    s_axis_txs_tvalid,
    output logic                    s_axis_txs_tready,
    output logic [31:0]             m_axis_txc_tdata,
    output logic [3:0]              m_axis_txc_tkeep,
    output logic                    m_axis_txc_tlast,
    output logic                    m_axis_txc_tvalid,
    input  logic                    m_axis_txc_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_txd_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_txd_tkeep,
    output logic                    m_axis_txd_tlast,
    output logic                    m_axis_txd_tvalid,
    input  logic                    m_axis_txd_tready,
    input  logic [1:0]              cfg_csum_mode,
    input  logic [15:0]             cfg_csum_begin,
    input  logic [15:0]             cfg_csum_insert,
    input  logic [15:0]             cfg_csum_init,
    output logic [31:0]             frame_count,
    output logic [31:0]             status_count,
    output logic                    busy
);

    state_t      state_reg;
    state_t      state_next;
    logic        txc_start;
    logic        txc_done;
    logic        in_txd;
    logic        txd_hs;
    logic        txs_hs_last;
    logic        txs_ready_reg;
    logic [31:0] frame_count_reg;
    logic [31:0] status_count_reg;
    logic        unused_txs_payload;

    axi_eth_txc_gen #(
        .TXC_WORDS (TXC_WORDS),
        .CSUM_EN   (CSUM_EN)
    ) u_txc_gen (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (txc_start),
        .active            (state_reg == ST_TXC),
        .cfg_csum_mode     (cfg_csum_mode),
        .cfg_csum_begin    (cfg_csum_begin),
        .cfg_csum_insert   (cfg_csum_insert),
        .cfg_csum_init     (cfg_csum_init),
        .m_axis_txc_tdata  (m_axis_txc_tdata),
        .m_axis_txc_tkeep  (m_axis_txc_tkeep),
        .m_axis_txc_tlast  (m_axis_txc_tlast),
        .m_axis_txc_tvalid (m_axis_txc_tvalid),
        .m_axis_txc_tready (m_axis_txc_tready),
        .txc_done          (txc_done)
    );

    assign in_txd      = (state_reg == ST_TXD);
    assign txd_hs      = in_txd & s_axis_txd_tvalid & m_axis_txd_tready;
    assign txs_hs_last = txs_ready_reg & s_axis_txs_tvalid & s_axis_txs_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        txc_start  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s_axis_txd_tvalid) begin
                    state_next = ST_TXC;
                    txc_start  = 1'b1;
                end
            end
            ST_TXC: begin
                if (txc_done) state_next = ST_TXD;
            end
            ST_TXD: begin
                if (txd_hs && s_axis_txd_tlast) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status and frame counters are independent and may step on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            txs_ready_reg    <= 1'b0;
            frame_count_reg  <= '0;
            status_count_reg <= '0;
        end else begin
            txs_ready_reg <= 1'b1;
            if (txd_hs && s_axis_txd_tlast) frame_count_reg <= frame_count_reg + 32'd1;
            if (txs_hs_last) status_count_reg <= status_count_reg + 32'd1;
        end
    end

    assign m_axis_txd_tdata   = s_axis_txd_tdata;
    assign m_axis_txd_tkeep   = s_axis_txd_tkeep;
    assign m_axis_txd_tlast   = in_txd & s_axis_txd_tlast;
    assign m_axis_txd_tvalid  = in_txd & s_axis_txd_tvalid;
    assign s_axis_txd_tready  = in_txd & m_axis_txd_tready;
    assign s_axis_txs_tready  = txs_ready_reg;
    assign frame_count        = frame_count_reg;
    assign status_count       = status_count_reg;
    assign busy               = (state_reg != ST_IDLE);
    assign unused_txs_payload = ^{s_axis_txs_tdata, s_axis_txs_tkeep};

endmodule
